// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: one BRAM port shared by LSU loads and a committed-store buffer; STORE_FWD_EN enables forwarding from buffered stores.
// Latency: grant is decided in the request cycle; the load response follows one cycle after acceptance.
// Backpressure: ld_req_ready drops when a store wins the port or on a RAW stall; st_enq_ready drops when the buffer is full.
module dmem_port_arbiter #(
  parameter int SB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_req_valid,
  input  logic [31:0]               ld_req_addr,
  output logic                      ld_req_ready,
  output logic                      ld_resp_valid,
  output logic [31:0]               ld_resp_data,
  input  logic                      st_enq_valid,
  input  logic [31:0]               st_enq_addr,
  input  logic [31:0]               st_enq_data,
  output logic                      st_enq_ready,
  output logic [31:0]               mem_addr,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      flush,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t     sb_mem [SB_DEPTH];
  sb_entry_t     head;
  logic [PW-1:0] rd_ptr, wr_ptr, scan_idx;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_cnt;
  logic          resp_pending, fwd_hit_q;
  logic [31:0]   fwd_data_q, fwd_data;
  logic          sb_full, st_pri, ld_hit, ld_ok, fwd_ok, st_grant, ld_grant, enq;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{ld_req_addr[1:0], st_enq_addr[1:0]};

  assign sb_count     = count_q;
  assign sb_empty     = (count_q == '0);
  assign sb_full      = (count_q == CW'(SB_DEPTH));
  assign st_enq_ready = !sb_full;
  assign enq          = st_enq_valid & st_enq_ready & !rst;
  assign head         = sb_mem[rd_ptr];

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    ld_hit   = 1'b0;
    fwd_data = '0;
    scan_idx = rd_ptr;
    for (int k = 0; k < SB_DEPTH; k++) begin
      scan_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count_q) && (sb_mem[scan_idx].addr == ld_req_addr[31:2])) begin
        ld_hit   = 1'b1;
        fwd_data = sb_mem[scan_idx].data;
      end
    end
  end

  assign st_pri   = sb_full | (starve_cnt == SW'(STARVE_LIMIT));
  assign ld_ok    = ld_req_valid & !flush & !ld_hit & !rst;
  assign st_grant = !sb_empty & (st_pri | !ld_ok) & !rst;
  assign ld_grant = ld_ok & !st_grant;

`ifdef STORE_FWD_EN
  assign fwd_ok = ld_req_valid & !flush & ld_hit & !rst;
`else
  assign fwd_ok = 1'b0;
`endif

  assign ld_req_ready = ld_grant | fwd_ok;

  always_comb begin
    mem_en    = st_grant | ld_grant;
    mem_we    = st_grant;
    mem_addr  = '0;
    mem_wdata = '0;
    if (st_grant) begin
      mem_addr  = {head.addr, 2'b00};
      mem_wdata = head.data;
    end else if (ld_grant) begin
      mem_addr  = {ld_req_addr[31:2], 2'b00};
    end
  end

  assign ld_resp_valid = resp_pending & !flush;
  assign ld_resp_data  = !resp_pending ? '0 : (fwd_hit_q ? fwd_data_q : mem_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      starve_cnt   <= '0;
      resp_pending <= 1'b0;
      fwd_hit_q    <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      if (enq)      wr_ptr <= wr_ptr + 1'b1;
      if (st_grant) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(enq) - CW'(st_grant);
      if (st_grant || sb_empty)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
      resp_pending <= ld_req_ready;
      fwd_hit_q    <= fwd_ok;
      if (fwd_ok) fwd_data_q <= fwd_data;
    end
  end

  // Entry payload needs no reset; validity is tracked by count_q and the pointers.
  always_ff @(posedge clk) begin
    if (enq) sb_mem[wr_ptr] <= '{addr: st_enq_addr[31:2], data: st_enq_data};
  end
endmodule
